rcu_rst_seq: RTL

- Parametrised reset sequencer for the RCU, generalising the fixed 7-output reset vector to NUM_CH ordered domains.
- Runs on one clock. After the clock is enabled/locked, it releases each domain's active-low reset in index order, with a programmable per-stage delay.
- Also handles a synchronised watchdog reset, clock-lock loss, and per-domain software reset pulses.
- Sits between the RCU register block (delay/soft-reset controls) and the clock/reset outputs of the RCU core.

---
 rtl/rcu_rst_seq_pkg.sv | 14 +
 rtl/rcu_rst_seq_sync_bit.sv | 24 ++
 rtl/rcu_rst_seq.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rcu_rst_seq_pkg.sv
// Shared RCU reset-sequencer definitions: FSM encoding and default sizing.
// Other RCU blocks import these so the reset-vector width tracks the clock-mode width.
package rcu_rst_seq_pkg;

  localparam int RCU_CLK_MODE_WIDTH = 7;

  localparam int RCU_RST_NUM_CH    = RCU_CLK_MODE_WIDTH;
  localparam int RCU_RST_CNT_WIDTH = 8;

  localparam logic [1:0] RCU_SEQ_IDLE = 2'b00;
  localparam logic [1:0] RCU_SEQ_WAIT = 2'b01;
  localparam logic [1:0] RCU_SEQ_DONE = 2'b10;

endpackage

// File: rtl/rcu_rst_seq_sync_bit.sv
// Single-bit multi-flop synchroniser, clears to 0 on reset.
// Latency STAGES edges; no flow control.
module rcu_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/rcu_rst_seq.sv
// Ordered release of NUM_CH active-low domain resets with per-stage delays, watchdog, lock-loss and soft resets.
// Domain k releases dly[k]+1 edges after domain k-1; lock must be seen on two edges before domain 0 starts counting.
module rcu_rst_seq
  import rcu_rst_seq_pkg::*;
#(
  parameter int NUM_CH      = RCU_RST_NUM_CH,
  parameter int CNT_WIDTH   = RCU_RST_CNT_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int SOFT_LEN    = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          en_i,
  input  logic                          wdt_rst_n_i,
  input  logic [NUM_CH*CNT_WIDTH-1:0]   dly_i,
  input  logic [NUM_CH-1:0]             soft_rst_i,
  input  logic                          wdt_clr_i,
  output logic [NUM_CH-1:0]             rst_n_o,
  output logic [$clog2(NUM_CH+1)-1:0]   stage_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          wdt_flag_o
);

  localparam int STW = $clog2(NUM_CH + 1);
  localparam int SCW = $clog2(SOFT_LEN + 1);

  logic [1:0]           state, nxt_state;
  logic [STW-1:0]       stage, nxt_stage;
  logic [CNT_WIDTH-1:0] cnt, nxt_cnt, cur_dly;
  logic [NUM_CH-1:0]    rst_q, nxt_rst;
  logic [NUM_CH-1:0]    mask, nxt_mask;
  logic [SCW-1:0]       soft_cnt, nxt_soft_cnt;
  logic                 go_q, busy_q, wdt_flag_q, wdt_s;

  rcu_sync_bit #(.STAGES(SYNC_STAGES)) u_wdt_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (wdt_rst_n_i),
    .q_o     (wdt_s)
  );

  always_comb begin
    cur_dly = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (stage == STW'(k)) cur_dly = dly_i[k*CNT_WIDTH +: CNT_WIDTH];
    end
  end

  always_comb begin
    nxt_state    = state;
    nxt_stage    = stage;
    nxt_cnt      = cnt;
    nxt_rst      = rst_q;
    nxt_mask     = mask;
    nxt_soft_cnt = soft_cnt;
    if (!wdt_s || (!en_i && state != RCU_SEQ_IDLE)) begin
      nxt_state    = RCU_SEQ_IDLE;
      nxt_stage    = '0;
      nxt_cnt      = '0;
      nxt_rst      = '0;
      nxt_mask     = '0;
      nxt_soft_cnt = '0;
    end else begin
      case (state)
        RCU_SEQ_IDLE: begin
          nxt_rst = '0;
          // go_q means lock and watchdog were both good on the previous edge too
          if (go_q && en_i) begin
            nxt_state = RCU_SEQ_WAIT;
            nxt_stage = '0;
            nxt_cnt   = '0;
          end
        end
        RCU_SEQ_WAIT: begin
          if (cnt == cur_dly) begin
            for (int k = 0; k < NUM_CH; k++) begin
              if (stage == STW'(k)) nxt_rst[k] = 1'b1;
            end
            nxt_cnt   = '0;
            nxt_stage = stage + STW'(1);
            if (stage == STW'(NUM_CH - 1)) nxt_state = RCU_SEQ_DONE;
          end else begin
            nxt_cnt = cnt + CNT_WIDTH'(1);
          end
        end
        RCU_SEQ_DONE: begin
          if (soft_rst_i != '0) begin
            nxt_mask     = mask | soft_rst_i;
            nxt_soft_cnt = '0;
          end else if (mask != '0) begin
            if (soft_cnt == SCW'(SOFT_LEN - 1)) begin
              nxt_mask     = '0;
              nxt_soft_cnt = '0;
            end else begin
              nxt_soft_cnt = soft_cnt + SCW'(1);
            end
          end
          nxt_rst = ~nxt_mask;
        end
        default: nxt_state = RCU_SEQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= RCU_SEQ_IDLE;
      stage      <= '0;
      cnt        <= '0;
      rst_q      <= '0;
      mask       <= '0;
      soft_cnt   <= '0;
      go_q       <= 1'b0;
      busy_q     <= 1'b0;
      wdt_flag_q <= 1'b0;
    end else begin
      state    <= nxt_state;
      stage    <= nxt_stage;
      cnt      <= nxt_cnt;
      rst_q    <= nxt_rst;
      mask     <= nxt_mask;
      soft_cnt <= nxt_soft_cnt;
      go_q     <= en_i & wdt_s;
      busy_q   <= (nxt_state == RCU_SEQ_WAIT) || (nxt_state == RCU_SEQ_IDLE && en_i) ||
                  (nxt_mask != '0);
      // synchroniser comes out of reset low, so the flag also records power-on
      if (!wdt_s) begin
        wdt_flag_q <= 1'b1;
      end else if (wdt_clr_i) begin
        wdt_flag_q <= 1'b0;
      end
    end
  end

  assign rst_n_o    = rst_q;
  assign stage_o    = stage;
  assign busy_o     = busy_q;
  assign done_o     = (state == RCU_SEQ_DONE);
  assign wdt_flag_o = wdt_flag_q;

endmodule
